// File: rtl/wb_stage.sv
// Writeback stage: register file write port arbitration between the MW
// pipeline slot and a small queue of pending multdiv results.
module wb_stage #(
    parameter int PEND_DEPTH = 2
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic [31:0] in_O,
    input  logic [31:0] in_D,
    input  logic [31:0] in_ir,
    input  logic [31:0] md_result,
    input  logic [4:0]  md_rd,
    input  logic        md_valid,
    output logic        md_accept,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic [2:0]  pend_count
);

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t       q     [PEND_DEPTH];
    ent_t       q_n   [PEND_DEPTH];
    logic [2:0] cnt;
    logic [2:0] cnt_n;

    logic [4:0]  opcode;
    logic [4:0]  alu_op;
    logic        slot_dec;
    logic [4:0]  slot_rd;
    logic [31:0] slot_data;
    logic        slot_we;
    logic        q_empty;
    logic        drain;
    logic        xfer;
    logic        direct;
    logic        enq;

    assign opcode = in_ir[31:27];
    assign alu_op = in_ir[6:2];

    always_comb begin
        slot_dec  = 1'b0;
        slot_rd   = in_ir[26:22];
        slot_data = in_O;
        unique case (1'b1)
            (opcode == OP_R) && (alu_op != ALU_MUL) && (alu_op != ALU_DIV):
                slot_dec = 1'b1;
            opcode == OP_ADDI:
                slot_dec = 1'b1;
            opcode == OP_LW: begin
                slot_dec  = 1'b1;
                slot_data = in_D;
            end
            opcode == OP_JAL: begin
                slot_dec = 1'b1;
                slot_rd  = 5'd31;
            end
            opcode == OP_SETX: begin
                slot_dec  = 1'b1;
                slot_rd   = 5'd30;
                slot_data = {5'b0, in_ir[26:0]};
            end
            default: ;
        endcase
    end

    // A write to r0 does not occupy the port, so the queue may drain.
    assign slot_we   = slot_dec && (slot_rd != 5'd0);
    assign q_empty   = (cnt == 3'd0);
    assign drain     = !slot_we && !q_empty;
    assign md_accept = !ctrl_reset && ((cnt < 3'(PEND_DEPTH)) || drain);
    assign xfer      = md_valid && md_accept;
    assign direct    = xfer && !slot_we && q_empty && (md_rd != 5'd0);
    assign enq       = xfer && !direct && (md_rd != 5'd0)
                     && !(slot_we && (md_rd == slot_rd));
    assign pend_count = cnt;

    always_comb begin
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'd0;
        if (!ctrl_reset) begin
            if (slot_we) begin
                ctrl_writeEnable = 1'b1;
                ctrl_writeReg    = slot_rd;
                data_writeReg    = slot_data;
            end else if (drain) begin
                ctrl_writeEnable = 1'b1;
                ctrl_writeReg    = q[0].rd;
                data_writeReg    = q[0].data;
            end else if (direct) begin
                ctrl_writeEnable = 1'b1;
                ctrl_writeReg    = md_rd;
                data_writeReg    = md_result;
            end
        end
    end

    // Survivors are compacted toward slot 0 so the head is always valid.
    always_comb begin
        int idx;
        logic keep;
        q_n = q;
        idx = 0;
        for (int i = 0; i < PEND_DEPTH; i++) begin
            keep = (3'(i) < cnt) && !(drain && (i == 0))
                 && !(slot_we && (q[i].rd == slot_rd));
            if (keep) begin
                for (int k = 0; k < PEND_DEPTH; k++)
                    if (k == idx) q_n[k] = q[i];
                idx = idx + 1;
            end
        end
        if (enq) begin
            for (int k = 0; k < PEND_DEPTH; k++)
                if (k == idx) q_n[k] = '{rd: md_rd, data: md_result};
            idx = idx + 1;
        end
        cnt_n = 3'(idx);
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            cnt <= 3'd0;
            for (int i = 0; i < PEND_DEPTH; i++) q[i] <= '0;
        end else begin
            cnt <= cnt_n;
            for (int i = 0; i < PEND_DEPTH; i++) q[i] <= q_n[i];
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: decode, bypass, queueing, kill and reset.
module tb_wb_stage;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic [31:0] in_O, in_D, in_ir;
    logic [31:0] md_result;
    logic [4:0]  md_rd;
    logic        md_valid;
    logic        md_accept;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [2:0]  pend_count;

    int errors = 0;
    int checks = 0;

    wb_stage #(.PEND_DEPTH(2)) dut (
        .clock(clock),
        .ctrl_reset(ctrl_reset),
        .in_O(in_O),
        .in_D(in_D),
        .in_ir(in_ir),
        .md_result(md_result),
        .md_rd(md_rd),
        .md_valid(md_valid),
        .md_accept(md_accept),
        .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg),
        .pend_count(pend_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input string tag, input logic we,
                      input logic [4:0] rd, input logic [31:0] d);
        #1;
        check({tag, ".we"}, 32'(ctrl_writeEnable), 32'(we));
        if (we) begin
            check({tag, ".rd"}, 32'(ctrl_writeReg), 32'(rd));
            check({tag, ".data"}, data_writeReg, d);
        end
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rd);
        return {5'b00101, rd, 22'd0};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rd,
                                          input logic [4:0] alu);
        return {5'b00000, rd, 15'd0, alu, 2'b00};
    endfunction

    localparam logic [31:0] SW = {5'b00111, 5'd3, 22'd0};

    task automatic md(input logic v, input logic [4:0] rd,
                      input logic [31:0] r);
        md_valid  = v;
        md_rd     = rd;
        md_result = r;
    endtask

    initial begin
        ctrl_reset = 1'b1;
        in_O = 32'd7; in_D = 32'd0; in_ir = addi(5'd5);
        md(1'b1, 5'd6, 32'h1);
        #1;
        check("rst.we", 32'(ctrl_writeEnable), 32'd0);
        check("rst.acc", 32'(md_accept), 32'd0);
        check("rst.rd", 32'(ctrl_writeReg), 32'd0);
        check("rst.data", data_writeReg, 32'd0);
        step();
        check("rst.pend", 32'(pend_count), 32'd0);
        ctrl_reset = 1'b0;
        md(1'b0, 5'd0, 32'd0);

        wr("addi", 1'b1, 5'd5, 32'd7);
        step();
        in_ir = {5'b01000, 5'd0, 22'd0}; in_D = 32'hDEADBEEF;
        wr("lw_r0", 1'b0, 5'd0, 32'd0);
        in_ir = {5'b01000, 5'd8, 22'd0};
        wr("lw", 1'b1, 5'd8, 32'hDEADBEEF);
        in_ir = {5'b10101, 27'h123};
        wr("setx", 1'b1, 5'd30, 32'h123);
        in_ir = {5'b00011, 27'h55}; in_O = 32'h40;
        wr("jal", 1'b1, 5'd31, 32'h40);
        in_ir = rtype(5'd3, 5'b00110);
        wr("mul", 1'b0, 5'd0, 32'd0);
        in_ir = rtype(5'd3, 5'b00111);
        wr("div", 1'b0, 5'd0, 32'd0);
        in_ir = rtype(5'd3, 5'b00000);
        wr("add", 1'b1, 5'd3, 32'h40);
        in_ir = SW;
        wr("sw", 1'b0, 5'd0, 32'd0);
        step();

        in_ir = 32'd0; md(1'b1, 5'd7, 32'h55);
        wr("byp", 1'b1, 5'd7, 32'h55);
        check("byp.acc", 32'(md_accept), 32'd1);
        step();
        check("byp.pend", 32'(pend_count), 32'd0);

        in_ir = addi(5'd4); in_O = 32'h11; md(1'b1, 5'd9, 32'h64);
        wr("col0", 1'b1, 5'd4, 32'h11);
        check("col0.acc", 32'(md_accept), 32'd1);
        step();
        check("col0.pend", 32'(pend_count), 32'd1);
        in_ir = SW; md(1'b0, 5'd0, 32'd0);
        wr("col1", 1'b1, 5'd9, 32'h64);
        step();
        check("col1.pend", 32'(pend_count), 32'd0);

        in_ir = addi(5'd1); in_O = 32'h1;
        md(1'b1, 5'd10, 32'hA1);
        check("full.a.acc", 32'(md_accept), 32'd1);
        step();
        md(1'b1, 5'd11, 32'hB2);
        check("full.b.acc", 32'(md_accept), 32'd1);
        step();
        check("full.pend2", 32'(pend_count), 32'd2);
        md(1'b1, 5'd13, 32'hC3);
        for (int i = 0; i < 2; i++) begin
            wr("full.hold", 1'b1, 5'd1, 32'h1);
            check("full.c.acc", 32'(md_accept), 32'd0);
            step();
            check("full.pendh", 32'(pend_count), 32'd2);
        end
        in_ir = SW;
        wr("drain.a", 1'b1, 5'd10, 32'hA1);
        check("drain.c.acc", 32'(md_accept), 32'd1);
        step();
        check("drain.pend", 32'(pend_count), 32'd2);
        md(1'b0, 5'd0, 32'd0);
        wr("drain.b", 1'b1, 5'd11, 32'hB2);
        step();
        wr("drain.c", 1'b1, 5'd13, 32'hC3);
        step();
        check("drain.empty", 32'(pend_count), 32'd0);
        wr("drain.none", 1'b0, 5'd0, 32'd0);

        in_ir = addi(5'd2); in_O = 32'h2; md(1'b1, 5'd12, 32'h99);
        step();
        check("kill.pend1", 32'(pend_count), 32'd1);
        in_ir = addi(5'd12); in_O = 32'hAA; md(1'b0, 5'd0, 32'd0);
        wr("kill.wr", 1'b1, 5'd12, 32'hAA);
        step();
        check("kill.pend0", 32'(pend_count), 32'd0);
        in_ir = SW;
        wr("kill.none", 1'b0, 5'd0, 32'd0);

        in_ir = addi(5'd14); in_O = 32'hE; md(1'b1, 5'd14, 32'h77);
        check("live.acc", 32'(md_accept), 32'd1);
        step();
        check("live.pend", 32'(pend_count), 32'd0);
        in_ir = SW; md(1'b0, 5'd0, 32'd0);
        wr("live.none", 1'b0, 5'd0, 32'd0);

        in_ir = 32'd0; md(1'b1, 5'd0, 32'h5);
        wr("r0.byp", 1'b0, 5'd0, 32'd0);
        check("r0.acc", 32'(md_accept), 32'd1);
        step();
        in_ir = addi(5'd1);
        step();
        check("r0.pend", 32'(pend_count), 32'd0);

        md(1'b1, 5'd20, 32'h20);
        step();
        md(1'b1, 5'd21, 32'h21);
        step();
        check("mrst.pend2", 32'(pend_count), 32'd2);
        ctrl_reset = 1'b1; in_ir = SW;
        wr("mrst.we", 1'b0, 5'd0, 32'd0);
        check("mrst.acc", 32'(md_accept), 32'd0);
        step();
        ctrl_reset = 1'b0; md(1'b0, 5'd0, 32'd0);
        check("mrst.pend0", 32'(pend_count), 32'd0);
        wr("mrst.none", 1'b0, 5'd0, 32'd0);
        step();
        wr("mrst.none2", 1'b0, 5'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
